// File: rtl/memory_access_stage.sv
// MEM pipeline stage with a req/ack data-memory port and the MEM/WB register.
// Handles byte-lane alignment for stores, load extraction/extension, wait stalls and timeout abort.
module memory_access_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        RegWrite_M_W,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;

  logic        is_load, access, f3_legal, misaligned, illegal, legal_access;
  logic        req, stall, misalign, buserr, bubble;
  logic [1:0]  off;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign off     = ALUResultM[1:0];
  assign is_load = (ResultSrcM == 2'b01);
  assign access  = MemWriteM | is_load;

  always_comb begin
    f3_legal = 1'b0;
    if (MemWriteM)
      f3_legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
    else
      f3_legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                 (funct3M == 3'b100) || (funct3M == 3'b101);
  end

  assign misaligned   = ((funct3M[1:0] == 2'b01) & off[0]) |
                        ((funct3M[1:0] == 2'b10) & (|off));
  assign illegal      = access & (~f3_legal | misaligned);
  assign legal_access = access & ~illegal;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req        = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    buserr     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        misalign = illegal;
        if (legal_access) begin
          req = 1'b1;
          if (!dmem_ack) begin
            stall      = 1'b1;
            state_next = S_WAIT;
            count_next = 8'd1;
          end
        end
      end
      S_WAIT: begin
        // ack wins over timeout when both land in the same cycle
        if (dmem_ack) begin
          req        = 1'b1;
          state_next = S_IDLE;
          count_next = 8'd0;
        end else if (count_reg < 8'(TIMEOUT)) begin
          req        = 1'b1;
          stall      = 1'b1;
          count_next = count_reg + 8'd1;
        end else begin
          buserr     = 1'b1;
          state_next = S_IDLE;
          count_next = 8'd0;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  assign bubble = misalign | buserr;

  // Gating with rst_n makes the request vanish the instant reset asserts.
  assign dmem_req  = req & rst_n;
  assign StallM    = stall & rst_n;
  assign MisalignM = misalign & rst_n;
  assign BusErrM   = buserr & rst_n;

  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << off;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << off;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    load_byte = dmem_rdata[7:0];
    case (off)
      2'd0: load_byte = dmem_rdata[7:0];
      2'd1: load_byte = dmem_rdata[15:8];
      2'd2: load_byte = dmem_rdata[23:16];
      2'd3: load_byte = dmem_rdata[31:24];
      default: load_byte = dmem_rdata[7:0];
    endcase
    load_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'd0, load_byte};
      3'b101:  load_ext = {16'd0, load_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_M_W <= 1'b0;
      ResultSrcW   <= 2'b00;
      ALUResultW   <= 32'd0;
      ReadDataW    <= 32'd0;
      RdW          <= 5'd0;
      PCPlus4W     <= 32'd0;
    end else if (stall || bubble) begin
      RegWrite_M_W <= 1'b0;
    end else begin
      RegWrite_M_W <= RegWriteM;
      ResultSrcW   <= ResultSrcM;
      ALUResultW   <= ALUResultM;
      ReadDataW    <= (is_load && !MemWriteM) ? load_ext : 32'd0;
      RdW          <= RdM;
      PCPlus4W     <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases plus randomized transactions
// checked against a transaction-level model of access legality, lanes, latency and write-back.
module tb_memory_access_stage;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, MisalignM, BusErrM;
  logic        RegWrite_M_W;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;

  int n_vec = 0;
  int n_err = 0;

  // write-back model state
  logic        m_rw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_rdata, m_pc;
  logic [4:0]  m_rd;

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .RegWrite_M_W(RegWrite_M_W), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag);
    chk({tag, " RegWrite_M_W"}, 32'(RegWrite_M_W), 32'(m_rw));
    chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(m_rs));
    chk({tag, " ALUResultW"}, ALUResultW, m_alu);
    chk({tag, " ReadDataW"}, ReadDataW, m_rdata);
    chk({tag, " RdW"}, 32'(RdW), 32'(m_rd));
    chk({tag, " PCPlus4W"}, PCPlus4W, m_pc);
  endtask

  // One instruction through MEM. delay = cycle index of ack (0 = same cycle), <0 = never.
  task automatic txn(input string tag, input bit rw, input logic [1:0] rs, input bit mw,
                     input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [31:0] pc, input int delay,
                     input logic [31:0] rdata);
    bit          is_ld, acc, f3ok, bad, loaded;
    int          size, off, eff_delay;
    logic [31:0] b, h, ext, exp_be, exp_wd;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc;
    dmem_rdata = rdata; dmem_ack = (delay == 0);

    is_ld = (rs == 2'b01) && !mw;
    acc   = mw || is_ld;
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    f3ok  = mw ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    bad   = acc && (!f3ok || (addr % size) != 0);
    off   = int'(addr % 4);
    b     = (rdata >> (8 * off)) & 32'hFF;
    h     = (rdata >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0:    ext = (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    ext = (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    ext = b;
      3'd5:    ext = h;
      default: ext = rdata;
    endcase
    if (!mw)          begin exp_be = 15; exp_wd = wd; end
    else if (f3 == 0) begin exp_be = 1 << off; exp_wd = (wd & 32'hFF) * 32'h01010101; end
    else if (f3 == 1) begin exp_be = 3 << off; exp_wd = (wd & 32'hFFFF) * 32'h00010001; end
    else              begin exp_be = 15; exp_wd = wd; end
    eff_delay = (delay < 0 || delay > TIMEOUT) ? -1 : delay;
    loaded = 1'b0;

    for (int c = 0; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (!acc || bad) begin
        chk({tag, " req"}, 32'(dmem_req), 0);
        chk({tag, " stall"}, 32'(StallM), 0);
        chk({tag, " misalign"}, 32'(MisalignM), 32'(bad));
        loaded = !bad;
        break;
      end
      if (c == 0) begin
        chk({tag, " addr"}, dmem_addr, addr & 32'hFFFFFFFC);
        chk({tag, " we"}, 32'(dmem_we), 32'(mw));
        chk({tag, " be"}, 32'(dmem_be), exp_be);
        if (mw) chk({tag, " wdata"}, dmem_wdata, exp_wd);
        chk({tag, " misalign"}, 32'(MisalignM), 0);
      end else begin
        chk({tag, " wait RegWrite_M_W"}, 32'(RegWrite_M_W), 0);
      end
      if (c == eff_delay) begin
        chk({tag, " req"}, 32'(dmem_req), 1);
        chk({tag, " stall"}, 32'(StallM), 0);
        loaded = 1'b1;
        break;
      end else if (c == TIMEOUT) begin
        chk({tag, " abort req"}, 32'(dmem_req), 0);
        chk({tag, " abort stall"}, 32'(StallM), 0);
        chk({tag, " buserr"}, 32'(BusErrM), 1);
        break;
      end else begin
        chk({tag, " req"}, 32'(dmem_req), 1);
        chk({tag, " stall"}, 32'(StallM), 1);
        chk({tag, " buserr"}, 32'(BusErrM), 0);
        @(posedge clk); #1;
        dmem_ack = (c + 1 == eff_delay);
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (loaded) begin
      m_rw = rw; m_rs = rs; m_alu = addr; m_rd = rd; m_pc = pc;
      m_rdata = is_ld ? ext : 32'd0;
    end else begin
      m_rw = 1'b0;
    end
    check_w(tag);
    $display("txn %s rs=%0d we=%0d f3=%0d addr=%h delay=%0d -> %s", tag, rs, mw, f3, addr, delay,
             !acc ? "alu" : bad ? "illegal" : loaded ? "done" : "abort");
  endtask

  initial begin
    int kind, r, dly;
    logic [2:0] f3;
    logic [1:0] rs;
    logic [2:0] ld_f3 [5];
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    rst_n = 1'b0;
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0;
    WriteDataM = 0; RdM = 0; PCPlus4M = 0; dmem_ack = 0; dmem_rdata = 0;
    m_rw = 0; m_rs = 0; m_alu = 0; m_rdata = 0; m_rd = 0; m_pc = 0;
    @(posedge clk); @(negedge clk);
    chk("reset req", 32'(dmem_req), 0);
    chk("reset stall", 32'(StallM), 0);
    check_w("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    txn("LW0", 1, 2'b01, 0, 3'd2, 32'h100, 0, 5'd3, 32'h1004, 0, 32'hDEADBEEF);
    txn("LB", 1, 2'b01, 0, 3'd0, 32'h103, 0, 5'd4, 32'h1008, 0, 32'h80123456);
    txn("LBU", 1, 2'b01, 0, 3'd4, 32'h103, 0, 5'd5, 32'h100C, 1, 32'h80123456);
    txn("SH", 0, 2'b00, 1, 3'd1, 32'h102, 32'h0000ABCD, 5'd0, 32'h1010, 3, 0);
    txn("LWmis", 1, 2'b01, 0, 3'd2, 32'h101, 0, 5'd6, 32'h1014, 0, 32'h12345678);
    txn("ALU", 1, 2'b00, 0, 3'd0, 32'h55AA55AA, 0, 5'd7, 32'h1018, 0, 0);
    txn("LWto", 1, 2'b01, 0, 3'd2, 32'h200, 0, 5'd8, 32'h101C, -1, 32'h0);
    txn("LHlast", 1, 2'b01, 0, 3'd1, 32'h202, 0, 5'd9, 32'h1020, TIMEOUT, 32'hF00D1234);
    txn("SBbadf3", 0, 2'b00, 1, 3'd4, 32'h300, 32'h11, 5'd0, 32'h1024, 0, 0);

    // reset in the middle of a wait
    RegWriteM = 1; ResultSrcM = 2'b01; MemWriteM = 0; funct3M = 3'd2; ALUResultM = 32'h400;
    dmem_ack = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst-wait req", 32'(dmem_req), 0);
    chk("rst-wait stall", 32'(StallM), 0);
    m_rw = 0; m_rs = 0; m_alu = 0; m_rdata = 0; m_rd = 0; m_pc = 0;
    check_w("rst-wait");
    $display("txn rst-wait: reset asserted during WAIT");
    ResultSrcM = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    txn("LWpost", 1, 2'b01, 0, 3'd2, 32'h104, 0, 5'd10, 32'h2000, 0, 32'hCAFEF00D);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 2));
      f3 = ($urandom_range(0, 3) != 0) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      if (kind == 2 && f3 > 2 && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 2));
      rs = (kind == 1) ? 2'b01 : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b00);
      r = int'($urandom_range(0, 7));
      dly = (r <= 4) ? r : (r == 5) ? TIMEOUT : (r == 6) ? -1 : 1;
      txn($sformatf("R%0d", i), 1'($urandom), rs, kind == 2, f3, $urandom, $urandom,
          5'($urandom), $urandom, dly, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
